muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide sequencer that sits beside the main ALU in the EX stage.
- Accepts one M-extension operation from EX, computes it over multiple cycles (radix-2 shift-add / restoring divide), holds busy_o to stall the pipeline, and pulses done_o with the result.
- The main ALU stays single-cycle; this block owns all multi-cycle sequencing.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide sequencer.
// The EX stage is the master; the sequencer is the slave.
interface muldiv_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic            flush_i;
   logic [2:0]      Funct3_i;
   logic [XLEN-1:0] op_a_i;
   logic [XLEN-1:0] op_b_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, flush_i, Funct3_i, op_a_i, op_b_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, flush_i, Funct3_i, op_a_i, op_b_i,
      output busy_o, done_o, result_o
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero operands skip the iteration loop and finish straight from PREP.
module muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input logic               clk,
   input logic               reset,
   muldiv_sequencer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [2:0]        f3;
   logic [XLEN-1:0]   a_q, b_q;
   logic [XLEN-1:0]   mcand;        // multiplicand magnitude or divisor magnitude
   logic [2*XLEN-1:0] acc;          // {high, low} product, or {remainder, quotient}
   logic              sa, sb;
   logic [CNT_W-1:0]  cnt;

   logic              accept;
   logic              is_div, a_signed, b_signed, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, ovf, early, short_cut;
   logic [XLEN-1:0]   short_result;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
   logic [XLEN-1:0]   quo_s, rem_s, fix_result;

   assign accept = (state == S_IDLE) && bus.start_i && !bus.flush_i;

   // Operand decode, evaluated on the registered operands while in PREP.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch behind.
      is_div       = f3[2];
      a_signed     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b110);
      b_signed     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
      neg_a        = a_signed && a_q[XLEN-1];
      neg_b        = b_signed && b_q[XLEN-1];
      mag_a        = neg_a ? -a_q : a_q;
      mag_b        = neg_b ? -b_q : b_q;
      div_zero     = is_div && (b_q == '0);
      ovf          = is_div && !f3[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
`ifdef MULDIV_EARLY_OUT_EN
      early        = is_div ? ((a_q == '0) && (b_q != '0)) : ((a_q == '0) || (b_q == '0));
`else
      early        = 1'b0;
`endif
      short_cut    = div_zero || ovf || early;
      short_result = '0;
      if (div_zero)  short_result = f3[1] ? a_q : '1;
      else if (ovf)  short_result = f3[1] ? '0 : a_q;
   end

   // One iteration of each algorithm, and the final sign fix-up.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      mul_nxt   = {mul_sum, acc[XLEN-1:1]};
      div_shift = acc[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, mcand};
      div_nxt   = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                   acc[XLEN-2:0], !div_diff[XLEN]};
      prod      = (sa ^ sb) ? -acc : acc;
      quo_s     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (f3)
         3'b000:                 fix_result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_result = quo_s;
         default:                fix_result = rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_PREP;
         S_PREP: if (bus.flush_i)                 state_nxt = S_IDLE;
                 else if (short_cut)              state_nxt = S_DONE;
                 else                             state_nxt = S_CALC;
         S_CALC: if (bus.flush_i)                 state_nxt = S_IDLE;
                 else if (cnt == CNT_W'(XLEN-1))  state_nxt = S_FIX;
         S_FIX:  if (bus.flush_i)                 state_nxt = S_IDLE;
                 else                             state_nxt = S_DONE;
         default:                                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
      bus.done_o = (state == S_DONE);
   end

   // Datapath; result_o only moves on the transition into DONE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         f3           <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mcand        <= '0;
         acc          <= '0;
         sa           <= 1'b0;
         sb           <= 1'b0;
         cnt          <= '0;
         bus.result_o <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               f3  <= bus.Funct3_i;
               a_q <= bus.op_a_i;
               b_q <= bus.op_b_i;
            end
            S_PREP: begin
               sa    <= neg_a;
               sb    <= neg_b;
               acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
               mcand <= is_div ? mag_b : mag_a;
               cnt   <= '0;
               if (short_cut && !bus.flush_i) bus.result_o <= short_result;
            end
            S_CALC: begin
               acc <= is_div ? div_nxt : mul_nxt;
               cnt <= cnt + CNT_W'(1);
            end
            S_FIX: if (!bus.flush_i) bus.result_o <= fix_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected results and done cycles,
// a monitor compares busy_o/done_o/result_o every cycle against that queue.
module tb_muldiv_sequencer;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.XLEN(XLEN)) bus();
   muldiv_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a, b, res;
      int          acc_cyc, done_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] hold = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = longint'(signed'(a)) * longint'(signed'(b)); return p[31:0]; end
         3'd1: begin p = longint'(signed'(a)) * longint'(signed'(b)); return p[63:32]; end
         3'd2: begin p = longint'(signed'(a)) * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(signed'(a) / signed'(b));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(signed'(a) % signed'(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      bit fast;
      fast = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2]) fast = fast || (a == 0 && b != 0);
      else      fast = (a == 0) || (b == 0);
`endif
      return fast ? 2 : XLEN + 3;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.Funct3_i = f;
      bus.op_a_i   = a;
      bus.op_b_i   = b;
      e.f3 = f; e.a = a; e.b = b;
      e.res      = ref_result(f, a, b);
      e.acc_cyc  = cyc;
      e.done_cyc = cyc + ref_latency(f, a, b);
      sb_q.push_back(e);
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      issue(f, a, b);
      wait_drain();
   endtask

   // Monitor: checks all outputs once per cycle, just after the active edge has settled.
   initial begin
      bit exp_done, exp_busy;
      @(posedge clk);
      forever begin
         #2;
         exp_done = (sb_q.size() > 0) && (cyc == sb_q[0].done_cyc);
         exp_busy = (sb_q.size() > 0) && (cyc > sb_q[0].acc_cyc) && (cyc < sb_q[0].done_cyc);
         check("busy_o", 32'(bus.busy_o), 32'(exp_busy));
         check("done_o", 32'(bus.done_o), 32'(exp_done));
         if (exp_done) begin
            check($sformatf("result f3=%0d a=%h b=%h", sb_q[0].f3, sb_q[0].a, sb_q[0].b),
                  bus.result_o, sb_q[0].res);
            hold = sb_q[0].res;
            void'(sb_q.pop_front());
         end else begin
            check("result_hold", bus.result_o, hold);
         end
         @(posedge clk);
      end
   end

   initial begin
      reset        = 1'b0;
      bus.start_i  = 1'b0;
      bus.flush_i  = 1'b0;
      bus.Funct3_i = '0;
      bus.op_a_i   = '0;
      bus.op_b_i   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      run(3'd0, 32'd7, 32'hFFFF_FFFD);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(3'd2, 32'hFFFF_FFFF, 32'd2);
      run(3'd4, 32'hFFFF_FFF9, 32'd2);
      run(3'd6, 32'hFFFF_FFF9, 32'd2);
      run(3'd5, 32'd100, 32'd7);
      run(3'd7, 32'd100, 32'd7);
      run(3'd5, 32'd5, 32'd0);
      run(3'd6, 32'd5, 32'd0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      for (int i = 0; i < 40; i++) run(3'($urandom_range(0, 7)), pick(), pick());

      // Flush mid-operation, with an extra start while busy that must be ignored.
      issue(3'd4, 32'd1000, 32'd3);
      repeat (4) @(negedge clk);
      bus.start_i  = 1'b1;
      bus.Funct3_i = 3'd0;
      bus.op_a_i   = 32'd9;
      bus.op_b_i   = 32'd9;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      bus.flush_i = 1'b1;
      void'(sb_q.pop_back());
      @(negedge clk);
      bus.flush_i = 1'b0;
      run(3'd0, 32'd7, 32'hFFFF_FFFD);

      // Flush beats start in IDLE: nothing is accepted.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset mid-CALC clears every output.
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (19) @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      hold = '0;
      @(negedge clk);
      reset = 1'b1;

      run(3'd0, 32'd0, 32'd123);
      run(3'd6, 32'd0, 32'd9);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
